// File: rtl/spi_frame_parser.sv
// spi_frame_parser: splits the SPI word stream into checksummed frames for NUM_CH channels
// and releases each frame's data downstream only after the checksum has been verified.
module spi_frame_parser #(
  parameter logic [7:0] BASE_ADDR   = 8'hAB,
  parameter int         NUM_CH      = 2,
  parameter int         MAX_SIZE    = 16,
  parameter int         TIMEOUT_CYC = 4096,
  localparam int        CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic [15:0]    in_data,
  input  logic           in_request,
  output logic [15:0]    out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           frm_valid,
  output logic           frm_ok,
  output logic [1:0]     frm_err,
  output logic [CHW-1:0] frm_ch,
  output logic [7:0]     frm_cmd,
  output logic [7:0]     frm_size,
  output logic [15:0]    frm_num,
  output logic           err_overrun
);
  localparam int IW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_NUM, S_DISC, S_SKIPHDR, S_SKIP, S_REL
  } state_t;

  state_t         r_state;
  logic [15:0]    r_buf [MAX_SIZE];
  logic [IW-1:0]  r_wr;
  logic [8:0]     r_cnt;
  logic [8:0]     r_rd;
  logic [15:0]    r_sum;
  logic [TW-1:0]  r_timer;
  logic [1:0]     r_err;
  logic [CHW-1:0] r_ch;
  logic [7:0]     r_cmd;
  logic [7:0]     r_size;
  logic [15:0]    r_num;
  logic           r_frm_valid;
  logic           r_frm_ok;
  logic [1:0]     r_frm_err;
  logic           r_overrun;

  logic [8:0]  w_off;
  logic        w_hit;
  logic        w_tstate;
  logic        w_timeout;
  logic        w_last;
  logic [15:0] w_sum;

  // addresses below BASE_ADDR wrap to >=257 in 9 bits, so one compare covers both bounds
  assign w_off     = {1'b0, in_data[15:8]} - {1'b0, BASE_ADDR};
  assign w_hit     = w_off < 9'(NUM_CH);
  assign w_sum     = r_sum + in_data;
  assign w_tstate  = r_state inside {S_HDR, S_DATA, S_CSUM, S_NUM, S_DISC, S_SKIPHDR, S_SKIP};
  assign w_timeout = w_tstate && !in_request && r_timer == TW'(TIMEOUT_CYC - 1);
  assign w_last    = r_rd == {1'b0, r_size} - 9'd1;

  assign out_valid   = r_state == S_REL;
  assign out_data    = out_valid ? r_buf[r_rd[IW-1:0]] : '0;
  assign out_last    = out_valid && w_last;
  assign frm_valid   = r_frm_valid;
  assign frm_ok      = r_frm_ok;
  assign frm_err     = r_frm_err;
  assign frm_ch      = r_ch;
  assign frm_cmd     = r_cmd;
  assign frm_size    = r_size;
  assign frm_num     = r_num;
  assign err_overrun = r_overrun;

  always_ff @(posedge clk)
    if (r_state == S_DATA && in_request) r_buf[r_wr] <= in_data;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= S_IDLE;
      r_wr        <= '0;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_sum       <= '0;
      r_timer     <= '0;
      r_err       <= '0;
      r_ch        <= '0;
      r_cmd       <= '0;
      r_size      <= '0;
      r_num       <= '0;
      r_frm_valid <= 1'b0;
      r_frm_ok    <= 1'b0;
      r_frm_err   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_frm_valid <= 1'b0;
      r_timer     <= (in_request || !w_tstate) ? '0 : r_timer + TW'(1);
      if (w_timeout) begin
        // foreign frames time out silently
        if (r_state != S_SKIPHDR && r_state != S_SKIP) begin
          r_frm_valid <= 1'b1;
          r_frm_ok    <= 1'b0;
          r_frm_err   <= 2'd3;
        end
        r_wr    <= '0;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:
            if (in_request && w_hit) begin
              r_ch    <= w_off[CHW-1:0];
              r_sum   <= in_data;
              r_err   <= '0;
              r_wr    <= '0;
              r_state <= S_HDR;
            end else if (in_request && in_data[15:8] != 8'h00) begin
              r_state <= S_SKIPHDR;
            end
          S_HDR:
            if (in_request) begin
              r_size <= in_data[15:8];
              r_cmd  <= in_data[7:0];
              r_sum  <= w_sum;
              if ({1'b0, in_data[15:8]} > 9'(MAX_SIZE)) begin
                r_err   <= 2'd2;
                r_cnt   <= {1'b0, in_data[15:8]} + 9'd1;
                r_state <= S_DISC;
              end else if (in_data[15:8] == 8'h00) begin
                r_state <= S_CSUM;
              end else begin
                r_cnt   <= {1'b0, in_data[15:8]} - 9'd1;
                r_state <= S_DATA;
              end
            end
          S_DATA:
            if (in_request) begin
              r_sum   <= w_sum;
              r_wr    <= r_wr + IW'(1);
              r_cnt   <= r_cnt - 9'd1;
              r_state <= (r_cnt == '0) ? S_CSUM : S_DATA;
            end
          S_CSUM:
            if (in_request) begin
              r_err   <= (in_data == r_sum) ? 2'd0 : 2'd1;
              r_state <= S_NUM;
            end
          S_NUM:
            if (in_request) begin
              r_num       <= in_data;
              r_frm_valid <= 1'b1;
              r_frm_ok    <= r_err == '0;
              r_frm_err   <= r_err;
              r_rd        <= '0;
              r_wr        <= '0;
              r_state     <= (r_err == '0 && r_size != '0) ? S_REL : S_IDLE;
            end
          S_DISC:
            if (in_request) begin
              r_cnt <= r_cnt - 9'd1;
              if (r_cnt == '0) begin
                r_frm_valid <= 1'b1;
                r_frm_ok    <= 1'b0;
                r_frm_err   <= r_err;
                r_state     <= S_IDLE;
              end
            end
          S_SKIPHDR:
            if (in_request) begin
              r_cnt   <= {1'b0, in_data[15:8]} + 9'd1;
              r_state <= S_SKIP;
            end
          S_SKIP:
            if (in_request) begin
              r_cnt   <= r_cnt - 9'd1;
              r_state <= (r_cnt == '0) ? S_IDLE : S_SKIP;
            end
          S_REL: begin
            if (in_request) r_overrun <= 1'b1;
            if (out_ready) begin
              r_rd    <= r_rd + 9'd1;
              r_state <= w_last ? S_IDLE : S_REL;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_parser.sv
// tb_spi_frame_parser: table-driven frame vectors plus hand-written timeout, overrun and reset sequences.
module tb_spi_frame_parser;
  logic        clk = 1'b0;
  logic        nRst;
  logic [15:0] in_data;
  logic        in_request;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frm_valid;
  logic        frm_ok;
  logic [1:0]  frm_err;
  logic [0:0]  frm_ch;
  logic [7:0]  frm_cmd;
  logic [7:0]  frm_size;
  logic [15:0] frm_num;
  logic        err_overrun;

  spi_frame_parser dut (
    .clk(clk), .nRst(nRst), .in_data(in_data), .in_request(in_request),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frm_valid(frm_valid), .frm_ok(frm_ok), .frm_err(frm_err), .frm_ch(frm_ch),
    .frm_cmd(frm_cmd), .frm_size(frm_size), .frm_num(frm_num), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          start;
    int          len;
    int          nfv;
    logic        ok;
    logic [1:0]  err;
    logic        ch;
    logic [7:0]  cmd;
    logic [7:0]  size;
    logic [15:0] num;
    int          ostart;
    int          nout;
  } vec_t;

  logic [15:0] stim [62] = '{
    16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000,
    16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCE, 16'h0000,
    16'hAC00, 16'h01B2, 16'h1234, 16'hBFE6, 16'h0007,
    16'h0100, 16'h00A0, 16'h01A0, 16'h0000, 16'hAB00, 16'h00A0, 16'hABA0, 16'h0000,
    16'hAB00, 16'h14A2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'hAB00, 16'h01B2, 16'h5678, 16'h032A, 16'h0009
  };
  logic [15:0] exp_out [8] = '{16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h1234, 16'h5678};
  vec_t vt [6];

  int          checks = 0;
  int          errors = 0;
  int          fv_cnt = 0;
  logic        cap_ok;
  logic [1:0]  cap_err;
  logic        cap_ch;
  logic [7:0]  cap_cmd;
  logic [7:0]  cap_size;
  logic [15:0] cap_num;
  logic [15:0] oq [$];
  logic        lq [$];

  always @(negedge clk)
    if (nRst) begin
      if (frm_valid) begin
        fv_cnt   <= fv_cnt + 1;
        cap_ok   <= frm_ok;
        cap_err  <= frm_err;
        cap_ch   <= frm_ch;
        cap_cmd  <= frm_cmd;
        cap_size <= frm_size;
        cap_num  <= frm_num;
      end
      if (out_valid && out_ready) begin
        oq.push_back(out_data);
        lq.push_back(out_last);
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    @(posedge clk);
    #1;
    in_data    = w;
    in_request = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_request = 1'b0;
    end
  endtask

  task automatic apply(input int k);
    int f0;
    int o0;
    f0 = fv_cnt;
    o0 = oq.size();
    for (int i = 0; i < vt[k].len; i++) send(stim[vt[k].start + i]);
    idle(40);
    chk($sformatf("v%0d frm_valid count", k), fv_cnt - f0, vt[k].nfv);
    if (vt[k].nfv > 0) begin
      chk($sformatf("v%0d frm_ok", k), cap_ok, vt[k].ok);
      chk($sformatf("v%0d frm_err", k), cap_err, vt[k].err);
      chk($sformatf("v%0d frm_ch", k), cap_ch, vt[k].ch);
      chk($sformatf("v%0d frm_cmd", k), cap_cmd, vt[k].cmd);
      chk($sformatf("v%0d frm_size", k), cap_size, vt[k].size);
      if (vt[k].err < 2) chk($sformatf("v%0d frm_num", k), cap_num, vt[k].num);
    end
    chk($sformatf("v%0d out count", k), oq.size() - o0, vt[k].nout);
    for (int i = 0; i < vt[k].nout && o0 + i < oq.size(); i++) begin
      chk($sformatf("v%0d out word %0d", k, i), oq[o0 + i], exp_out[vt[k].ostart + i]);
      chk($sformatf("v%0d out_last %0d", k, i), lq[o0 + i], i == vt[k].nout - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int o0;
    int n;
    vt[0] = '{0,  10, 1, 1'b1, 2'd0, 1'b0, 8'hA2, 8'h06, 16'h0000, 0, 6};
    vt[1] = '{10, 10, 1, 1'b0, 2'd1, 1'b0, 8'hA2, 8'h06, 16'h0000, 0, 0};
    vt[2] = '{20, 5,  1, 1'b1, 2'd0, 1'b1, 8'hB2, 8'h01, 16'h0007, 6, 1};
    vt[3] = '{25, 8,  1, 1'b1, 2'd0, 1'b0, 8'hA0, 8'h00, 16'h0000, 0, 0};
    vt[4] = '{33, 24, 1, 1'b0, 2'd2, 1'b0, 8'hA2, 8'h14, 16'h0000, 0, 0};
    vt[5] = '{57, 5,  1, 1'b1, 2'd0, 1'b0, 8'hB2, 8'h01, 16'h0009, 7, 1};
    nRst       = 1'b0;
    in_data    = '0;
    in_request = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset frm_valid", frm_valid, 0);
    chk("reset frm_ok", frm_ok, 0);
    chk("reset frm_err", frm_err, 0);
    chk("reset frm_num", frm_num, 0);
    chk("reset err_overrun", err_overrun, 0);
    #1 nRst = 1'b1;
    idle(2);

    for (int k = 0; k < 6; k++) apply(k);

    // inactivity timeout inside a matched frame
    send(16'hAB00);
    send(16'h03A2);
    send(16'h0001);
    f0 = fv_cnt;
    n  = 0;
    while (fv_cnt == f0 && n < 5000) begin
      @(posedge clk);
      #1;
      in_request = 1'b0;
      n++;
    end
    chk("timeout frm_valid count", fv_cnt - f0, 1);
    chk("timeout latency in window", (n >= 4090 && n <= 4105), 1);
    chk("timeout frm_err", cap_err, 3);
    chk("timeout frm_ok", cap_ok, 0);
    idle(3);
    apply(0);

    // stalled release with a word arriving mid-release
    out_ready = 1'b0;
    o0 = oq.size();
    for (int i = 0; i < 10; i++) send(stim[i]);
    idle(5);
    chk("stall out_valid", out_valid, 1);
    chk("stall out_data", out_data, 16'hFFA1);
    chk("stall err_overrun before", err_overrun, 0);
    send(16'h1234);
    idle(2);
    chk("err_overrun set", err_overrun, 1);
    out_ready = 1'b1;
    idle(20);
    chk("overrun out count", oq.size() - o0, 6);
    for (int i = 0; i < 6 && o0 + i < oq.size(); i++)
      chk($sformatf("overrun out word %0d", i), oq[o0 + i], exp_out[i]);
    chk("overrun out_valid drained", out_valid, 0);
    chk("err_overrun sticky", err_overrun, 1);

    // asynchronous reset mid-frame
    send(16'hAB00);
    send(16'h03A2);
    send(16'h0001);
    #3 nRst = 1'b0;
    #1;
    chk("async reset err_overrun", err_overrun, 0);
    chk("async reset frm_size", frm_size, 0);
    chk("async reset out_valid", out_valid, 0);
    #2 nRst = 1'b1;
    in_request = 1'b0;
    idle(3);
    apply(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
